interchange_frame_controller: RTL and testbench
===============================================

Name: interchange_frame_controller

Overview:
- Frame-level sequencer for the real/imaginary interchange stage of the 64-point FFT processor.
- Accepts one 64-sample complex frame per Start over a valid/ready stream and drives the interchange Swap select from a per-frame Inverse mode (swap-in/swap-out IFFT-via-FFT trick).
- Registers each swapped sample into a one-deep output skid stage, marks the last sample and signals frame completion.
- Sits between the input sample buffer and the butterfly pipeline; a second instance sits at the FFT output.

Parameters:
- N_POINTS, 64, samples per frame.
- CNT_WIDTH, 6, sample counter width; must satisfy 2^CNT_WIDTH >= N_POINTS.
- DATA_WIDTH, 32, complex sample width: real in [31:16], imaginary in [15:0].

Ports:
- CLK  input  1  system clock, rising edge.
- RST_n  input  1  reset, synchronous, active-low.
- Start  input  1  begin a frame; sampled only in IDLE.
- Inverse  input  1  frame mode, latched on accepted Start: 1 = swap, 0 = pass.
- In_Valid  input  1  input sample valid.
- In_Ready  output  1  controller can accept a sample.
- In_Data  input  DATA_WIDTH  input complex sample.
- Out_Valid  output  1  output register holds a sample.
- Out_Ready  input  1  downstream accepts the sample.
- Out_Data  output  DATA_WIDTH  swapped or passed sample.
- Out_Last  output  1  qualifies the final sample of the frame; valid only with Out_Valid.
- Swap  output  1  current interchange select, equal to latched mode.
- Busy  output  1  high in RUN and DRAIN.
- Done  output  1  one-cycle pulse when the last sample leaves.

Behaviour:
- Reset (RST_n=0 at a CLK edge):
  - State goes to IDLE; count=0; mode_r=0.
  - Out_Valid, Out_Last, Out_Data, Done, Busy and Swap are all 0.
  - Reset mid-frame discards the frame with no Done pulse.
- States are IDLE, RUN and DRAIN.
- IDLE:
  - In_Ready=0.
  - Start=1: mode_r<=Inverse, count<=0, next state RUN.
  - Inverse is ignored without Start.
- RUN:
  - In_Ready = !Out_Valid || Out_Ready.
  - A transfer occurs when In_Valid && In_Ready.
  - On a transfer:
    - Out_Data <= (mode_r ? {In_Data[15:0], In_Data[31:16]} : In_Data).
    - Out_Valid <= 1; Out_Last <= (count == N_POINTS-1); count <= count+1.
  - Transfer at count = N_POINTS-1: count wraps to 0, next state DRAIN.
  - Output accepted (Out_Ready) with no new transfer in the same cycle: Out_Valid <= 0.
  - Simultaneous consume and transfer: the register is reloaded with no bubble, giving full throughput of 1 sample/cycle.
- DRAIN:
  - In_Ready=0.
  - When Out_Valid && Out_Ready: Out_Valid<=0, Out_Last<=0, Done<=1 for one cycle, next state IDLE.
- Latency: In_Data to Out_Data is exactly 1 cycle.
- Backpressure:
  - While Out_Valid && !Out_Ready, Out_Data and Out_Last hold stable and In_Ready=0.
- Start handling:
  - Start while Busy is ignored.
  - Start in the Done cycle is accepted, because the state is already IDLE.
- Swap reflects mode_r.
  - It is stable for the whole frame and changes only on an accepted Start.
- Busy = (state != IDLE).
- Data width rule: pure 16-bit half exchange; no arithmetic and no sign handling.

Decomposition:
- Shared package fft_pkg:
  - state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2;
  - N_POINTS=64;
  - DATA_WIDTH=32;
  - HALF_WIDTH=16.
- Sub-module: existing real_imaginary_interchange instantiated for the swap.
  - A32=In_Data, Swap=mode_r, R32 feeds the output register.
- Counter and FSM stay inline.

Test Plan:
- Reset: hold RST_n=0 for 3 cycles, then release -> all outputs 0, state IDLE, In_Ready=0.
- Pass frame: Start with Inverse=0, feed samples 0x0001_0002 .. continuously, Out_Ready=1 -> outputs equal the inputs 1 cycle later; Out_Last only on sample 64; Done pulses once 1 cycle after the last output handshake; Swap=0.
- Swap frame: Start with Inverse=1, In_Data=0x1234_ABCD -> Out_Data=0xABCD_1234; Swap=1 for the whole frame.
- Backpressure: random Out_Ready at 50% and random In_Valid -> no sample lost or duplicated, Out_Data stable while stalled, exactly 64 outputs, Out_Last on the 64th.
- Mode/Start protection: toggle Inverse and pulse Start mid-frame -> Swap unchanged, no restart, count continues; Start in the Done cycle begins a new frame immediately.
- Mid-frame reset: assert RST_n=0 after 20 samples -> next cycle Out_Valid=0 and Busy=0, no Done pulse; the following frame has Out_Last on its own 64th sample.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point FFT datapath: frame sizes and the
// interchange controller state encoding.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int N_POINTS   = 64;
  localparam int DATA_WIDTH = 32;
  localparam int HALF_WIDTH = 16;

endpackage

// File: rtl/real_imaginary_interchange.sv
// Real/imaginary half exchange. Used for the swap-in/swap-out IFFT-via-FFT trick.
// Pure bit-field exchange with no arithmetic and no sign handling.
module real_imaginary_interchange
  import fft_pkg::*;
#(
  parameter int HALF = HALF_WIDTH
) (
  input  logic [2*HALF-1:0] A32,
  input  logic              Swap,
  output logic [2*HALF-1:0] R32
);

  assign R32 = Swap ? {A32[HALF-1:0], A32[2*HALF-1:HALF]} : A32;

endmodule

// File: rtl/interchange_frame_controller.sv
// Frame sequencer for the FFT interchange stage: accepts one frame per Start,
// swaps or passes each sample into a one-deep output register, flags the last sample.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for Start; mode latched on accept
//   RUN   | accepting samples, 1 sample/cycle when downstream keeps up
//   DRAIN | last sample held in output register until consumed
module interchange_frame_controller #(
  parameter int N_POINTS   = 64,
  parameter int CNT_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  Start,
  input  logic                  Inverse,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic                  Out_Last,
  output logic                  Swap,
  output logic                  Busy,
  output logic                  Done
);
  import fft_pkg::*;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   count;
  logic                   mode_r;
  logic [DATA_WIDTH-1:0]  swapped;
  logic                   in_fire;
  logic                   last_cnt;

  real_imaginary_interchange #(
    .HALF (DATA_WIDTH / 2)
  ) u_interchange (
    .A32  (In_Data),
    .Swap (mode_r),
    .R32  (swapped)
  );

  // Skid-free handshake: the register may reload in the same cycle it is consumed.
  assign In_Ready = (state == RUN) && (!Out_Valid || Out_Ready);
  assign in_fire  = In_Valid && In_Ready;
  assign last_cnt = (count == CNT_WIDTH'(N_POINTS - 1));
  assign Swap     = mode_r;
  assign Busy     = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state     <= IDLE;
      count     <= '0;
      mode_r    <= 1'b0;
      Out_Valid <= 1'b0;
      Out_Last  <= 1'b0;
      Out_Data  <= '0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            mode_r <= Inverse;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            Out_Data  <= swapped;
            Out_Valid <= 1'b1;
            Out_Last  <= last_cnt;
            if (last_cnt) begin
              count <= '0;
              state <= DRAIN;
            end else begin
              count <= count + 1'b1;
            end
          end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (Out_Valid && Out_Ready) begin
            Out_Valid <= 1'b0;
            Out_Last  <= 1'b0;
            Done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interchange_frame_controller.sv
// Bench for interchange_frame_controller: randomized frames checked against a
// transaction-level model (queue of expected output samples).
module tb_interchange_frame_controller;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        Start = 1'b0;
  logic        Inverse = 1'b0;
  logic        In_Valid = 1'b0;
  logic [31:0] In_Data = '0;
  logic        Out_Ready = 1'b0;
  logic        In_Ready;
  logic        Out_Valid;
  logic [31:0] Out_Data;
  logic        Out_Last;
  logic        Swap;
  logic        Busy;
  logic        Done;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  interchange_frame_controller #(
    .N_POINTS   (64),
    .CNT_WIDTH  (6),
    .DATA_WIDTH (32)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .Start     (Start),
    .Inverse   (Inverse),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Out_Last  (Out_Last),
    .Swap      (Swap),
    .Busy      (Busy),
    .Done      (Done)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] xform(input bit inv, input logic [31:0] d);
    return inv ? {d[15:0], d[31:16]} : d;
  endfunction

  // dmode: 0 = counting pattern, 1 = fixed value, 2 = random
  task automatic run_frame(input bit inv, input int vpct, input int rpct,
                           input int dmode, input logic [31:0] fixval,
                           input bit poke, input int abort_at);
    logic [31:0] q[$];
    logic [31:0] d;
    int  sent;
    int  outs;
    int  cyc;
    bit  done_exp;
    bit  finished;
    bit  exp_ov;
    bit  exp_ir;
    bit  in_fire;
    bit  out_fire;
    sent = 0; outs = 0; cyc = 0; done_exp = 0; finished = 0;

    chk1("start_idle", Busy, 1'b0);
    Start = 1'b1; Inverse = inv; In_Valid = 1'b0; Out_Ready = 1'b0;
    step();
    Start = 1'b0; Inverse = ~inv;
    chk1("start_busy", Busy, 1'b1);
    chk1("start_swap", Swap, inv);
    chk1("start_out_valid", Out_Valid, 1'b0);

    while (!finished && cyc < 3000) begin
      cyc++;
      if (abort_at > 0 && sent == abort_at) begin
        RST_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'($urandom_range(0, 1));
        step();
        chk1("abort_out_valid", Out_Valid, 1'b0);
        chk1("abort_busy", Busy, 1'b0);
        chk1("abort_done", Done, 1'b0);
        chk1("abort_swap", Swap, 1'b0);
        RST_n = 1'b1; Out_Ready = 1'b0;
        step();
        chk1("abort_done_after", Done, 1'b0);
        chk1("abort_in_ready", In_Ready, 1'b0);
        return;
      end
      exp_ov = (q.size() != 0);
      chk1("out_valid", Out_Valid, exp_ov);
      if (exp_ov) begin
        chk32("out_data", Out_Data, q[0]);
        chk1("out_last", Out_Last, outs == 63);
      end
      chk1("swap_stable", Swap, inv);
      if (poke) begin
        Start   = 1'($urandom_range(0, 1));
        Inverse = 1'($urandom_range(0, 1));
      end
      case (dmode)
        0:       d = {16'(sent + 1), 16'(sent + 2)};
        1:       d = fixval;
        default: d = $urandom;
      endcase
      In_Valid  = (sent < 64) && ($urandom_range(1, 100) <= vpct);
      In_Data   = In_Valid ? d : $urandom;
      Out_Ready = ($urandom_range(1, 100) <= rpct);
      #1;
      exp_ir = (sent < 64) && (!exp_ov || Out_Ready);
      chk1("in_ready", In_Ready, exp_ir);
      in_fire  = In_Valid && exp_ir;
      out_fire = exp_ov && Out_Ready;
      done_exp = out_fire && (outs == 63);
      if (out_fire) begin
        void'(q.pop_front());
        outs++;
      end
      if (in_fire) begin
        q.push_back(xform(inv, d));
        sent++;
      end
      step();
      chk1("done", Done, done_exp);
      chk1("busy", Busy, !done_exp);
      if (done_exp) finished = 1;
    end
    Start = 1'b0; Inverse = 1'b0; In_Valid = 1'b0;
    chk1("frame_complete", finished, 1'b1);
    chk32("output_count", 32'(outs), 32'd64);
  endtask

  initial begin
    RST_n = 1'b0;
    repeat (3) step();
    RST_n = 1'b1;
    step();
    chk1("rst_out_valid", Out_Valid, 1'b0);
    chk1("rst_out_last", Out_Last, 1'b0);
    chk32("rst_out_data", Out_Data, 32'h0);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_swap", Swap, 1'b0);
    chk1("rst_in_ready", In_Ready, 1'b0);

    // Inverse without Start must not change the mode
    Inverse = 1'b1;
    step();
    step();
    chk1("idle_inverse_ignored", Swap, 1'b0);
    chk1("idle_not_busy", Busy, 1'b0);
    Inverse = 1'b0;

    // Full-rate pass frame, then a swap frame started in the Done cycle
    run_frame(1'b0, 100, 100, 0, 32'h0, 1'b0, 0);
    run_frame(1'b1, 100, 100, 1, 32'h1234_ABCD, 1'b0, 0);
    // Random valid/ready with backpressure
    run_frame(1'($urandom_range(0, 1)), 60, 50, 2, 32'h0, 1'b0, 0);
    run_frame(1'b0, 50, 50, 2, 32'h0, 1'b0, 0);
    // Start/Inverse toggling mid-frame
    run_frame(1'b1, 70, 60, 2, 32'h0, 1'b1, 0);
    // Mid-frame reset after 20 samples, then a clean frame
    run_frame(1'b1, 80, 70, 0, 32'h0, 1'b0, 20);
    run_frame(1'b0, 75, 50, 0, 32'h0, 1'b0, 0);

    step();
    chk1("final_idle", Busy, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
